// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging two AXI-stream byte sources onto one uart_tx input,
// granting bursts of up to MAX_BURST bytes, optionally prefixed by a source tag byte.
module uart_tx_arbiter #(
    parameter int                N_BITS    = 8,
    parameter int                MAX_BURST = 16,
    parameter bit                TAG_EN    = 1'b1,
    parameter logic [N_BITS-1:0] TAG0      = 8'hA0,
    parameter logic [N_BITS-1:0] TAG1      = 8'hA1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [N_BITS-1:0] s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [N_BITS-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [N_BITS-1:0]   m_tdata_q, m_tdata_d;
    logic                m_tvalid_q, m_tvalid_d;

    logic                slot_free_s;
    logic                sel_valid_s;
    logic [N_BITS-1:0]   sel_data_s;
    logic                pick_s;
    logic                in_data_s;

    assign slot_free_s = !m_tvalid_q || m_tready;
    assign sel_valid_s = grant_q[1] ? s1_tvalid : s0_tvalid;
    assign sel_data_s  = grant_q[1] ? s1_tdata  : s0_tdata;
    // On a tie the source that did not win last time is chosen.
    assign pick_s      = (s0_tvalid && s1_tvalid) ? !last_q : s1_tvalid;
    assign in_data_s   = (state_q == DATA);

    // Readies are only offered in DATA so no byte can slip ahead of its tag.
    assign s0_tready = in_data_s && grant_q[0] && slot_free_s;
    assign s1_tready = in_data_s && grant_q[1] && slot_free_s;

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

    // Next-state, grant, burst count and output holding register logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q && !m_tready;

        case (state_q)
            IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    grant_d = pick_s ? 2'b10 : 2'b01;
                    last_d  = pick_s;
                    cnt_d   = 8'd0;
                    state_d = TAG_EN ? HDR : DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (slot_free_s) begin
                    m_tdata_d  = grant_q[1] ? TAG1 : TAG0;
                    m_tvalid_d = 1'b1;
                    state_d    = DATA;
                end else begin
                    state_d = HDR;
                end
            end
            DATA: begin
                if (slot_free_s && sel_valid_s) begin
                    m_tdata_d  = sel_data_s;
                    m_tvalid_d = 1'b1;
                    cnt_d      = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == MAX_BURST_C) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                    end else begin
                        state_d = DATA;
                    end
                end else if (slot_free_s) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= 8'd0;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut_a has tags and MAX_BURST=4,
// dut_b has no tags and MAX_BURST=2.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data  [4];
    logic       s_valid [4];
    logic       s_ready [4];
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_ready [2];
    logic [1:0] grant   [2];
    logic       busy    [2];

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] got_a [$];
    logic [7:0] got_b [$];
    int         cyc_b [$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_BITS(8), .MAX_BURST(4), .TAG_EN(1'b1),
                      .TAG0(8'hA0), .TAG1(8'hA1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(s_data[0]), .s0_tvalid(s_valid[0]), .s0_tready(s_ready[0]),
        .s1_tdata(s_data[1]), .s1_tvalid(s_valid[1]), .s1_tready(s_ready[1]),
        .m_tdata(m_data[0]), .m_tvalid(m_valid[0]), .m_tready(m_ready[0]),
        .grant(grant[0]), .busy(busy[0])
    );

    uart_tx_arbiter #(.N_BITS(8), .MAX_BURST(2), .TAG_EN(1'b0),
                      .TAG0(8'hA0), .TAG1(8'hA1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(s_data[2]), .s0_tvalid(s_valid[2]), .s0_tready(s_ready[2]),
        .s1_tdata(s_data[3]), .s1_tvalid(s_valid[3]), .s1_tready(s_ready[3]),
        .m_tdata(m_data[1]), .m_tvalid(m_valid[1]), .m_tready(m_ready[1]),
        .grant(grant[1]), .busy(busy[1])
    );

    // Cycle stamp for gap measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && m_valid[0] && m_ready[0]) got_a.push_back(m_data[0]);
        if (rst_n && m_valid[1] && m_ready[1]) begin
            got_b.push_back(m_data[1]);
            cyc_b.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check_eq({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check_eq({tag, "_byte"}, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_mvalid", 32'(m_valid[0]), 32'd0);
        check_eq("rst_mdata",  32'(m_data[0]),  32'd0);
        check_eq("rst_grant",  32'(grant[0]),   32'd0);
        check_eq("rst_busy",   32'(busy[0]),    32'd0);
        check_eq("rst_tready", 32'({s_ready[1], s_ready[0]}), 32'd0);
    endtask

    // Present n bytes first, first+stride, ... on source idx, one per handshake.
    task automatic drive(input int idx, input logic [7:0] first, input logic [7:0] stride, input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            s_data[idx]  = first + stride * 8'(i);
            s_valid[idx] = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = s_ready[idx];
            end
            if (!acc) check_eq("drv_accept", 32'(acc), 32'd1);
            @(posedge clk);
            #1;
        end
        s_valid[idx] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = 8'h00;
        end
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        got_a.delete();
        got_b.delete();
        cyc_b.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic seen;

        // Reset state, then an asynchronous reset in the middle of a stalled burst.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = 8'h00;
        end
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        #1;
        check_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        m_ready[0] = 1'b0;
        s_data[0]  = 8'h5A;
        s_valid[0] = 1'b1;
        step();
        check_eq("req_to_grant", 32'(grant[0]), 32'd1);
        step();
        check_eq("tag_latency_valid", 32'(m_valid[0]), 32'd1);
        check_eq("tag_latency_data",  32'(m_data[0]),  32'hA0);
        check_eq("pre_rst_busy",      32'(busy[0]),    32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        s_data[1]  = 8'h6B;
        s_valid[1] = 1'b1;
        #2;
        rst_n = 1'b1;
        step();
        check_eq("rr_first_s0", 32'(grant[0]), 32'd1);

        // Single source, three bytes with tag.
        do_reset();
        drive(0, 8'h11, 8'h11, 3);
        repeat (4) step();
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        check_stream("single", got_a, exp_q);
        check_eq("single_grant_idle", 32'(grant[0]), 32'd0);
        check_eq("single_busy_idle",  32'(busy[0]),  32'd0);

        // Both sources saturated: bursts of four, alternating tags.
        do_reset();
        fork
            drive(0, 8'h01, 8'h01, 10);
            drive(1, 8'h81, 8'h01, 10);
        join
        repeat (4) step();
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA1, 8'h81, 8'h82, 8'h83, 8'h84,
                  8'hA0, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'hA1, 8'h85, 8'h86, 8'h87, 8'h88,
                  8'hA0, 8'h09, 8'h0A,
                  8'hA1, 8'h89, 8'h8A};
        check_stream("burst", got_a, exp_q);

        // Backpressure with 0x55 held in the output register.
        do_reset();
        fork
            drive(0, 8'h55, 8'h11, 3);
            begin
                seen = 1'b0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    step();
                    if (m_valid[0] && m_data[0] == 8'h55) seen = 1'b1;
                end
                check_eq("bp_seen", 32'(seen), 32'd1);
                m_ready[0] = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check_eq("bp_hold_data",  32'(m_data[0]),  32'h55);
                    check_eq("bp_hold_valid", 32'(m_valid[0]), 32'd1);
                    check_eq("bp_tready",     32'({s_ready[1], s_ready[0]}), 32'd0);
                end
                step();
                m_ready[0] = 1'b1;
            end
        join
        repeat (4) step();
        exp_q = '{8'hA0, 8'h55, 8'h66, 8'h77};
        check_stream("bp", got_a, exp_q);

        // Idle release and fairness, cycle by cycle.
        do_reset();
        s_data[0]  = 8'h10;
        s_valid[0] = 1'b1;
        step();
        check_eq("fair_g_s0", 32'(grant[0]), 32'd1);
        s_data[1]  = 8'h20;
        s_valid[1] = 1'b1;
        step();
        check_eq("fair_ready_s0", 32'({s_ready[1], s_ready[0]}), 32'd1);
        step();
        s_valid[0] = 1'b0;
        check_eq("fair_g_hold", 32'(grant[0]), 32'd1);
        step();
        check_eq("fair_release", 32'(grant[0]), 32'd0);
        s_data[0]  = 8'h11;
        s_valid[0] = 1'b1;
        step();
        check_eq("fair_g_s1", 32'(grant[0]), 32'd2);
        step();
        check_eq("fair_ready_s1", 32'({s_ready[1], s_ready[0]}), 32'd2);
        step();
        s_valid[1] = 1'b0;
        step();
        check_eq("fair_release_s1", 32'(grant[0]), 32'd0);
        step();
        check_eq("fair_g_s0_again", 32'(grant[0]), 32'd1);
        step();
        step();
        s_valid[0] = 1'b0;
        repeat (3) step();
        exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h20, 8'hA0, 8'h11};
        check_stream("fair", got_a, exp_q);

        // No tags: pure data with a single-cycle bubble between bursts.
        do_reset();
        fork
            drive(2, 8'h01, 8'h01, 4);
            drive(3, 8'h81, 8'h01, 4);
        join
        repeat (4) step();
        exp_q = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84};
        check_stream("notag", got_b, exp_q);
        if (cyc_b.size() >= 5) begin
            check_eq("notag_gap_in",  32'(cyc_b[1] - cyc_b[0]), 32'd1);
            check_eq("notag_gap_sw1", 32'(cyc_b[2] - cyc_b[1]), 32'd2);
            check_eq("notag_gap_sw2", 32'(cyc_b[4] - cyc_b[3]), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
